// File: rtl/mult_tree_pipe.sv
// -----------------------------------------------------------------------------
// mult_tree_pipe
//   Fully pipelined unsigned product tree. NUM_IN operands of DATA_W bits are
//   registered and then multiplied pairwise through a balanced binary tree.
//   Each tree level has one register stage. A final format stage turns the
//   full-precision product into OUT_W bits: truncate-high, saturate-low or
//   round-high. Valid/ready flow control stalls the whole pipeline when the
//   result is valid and downstream is not ready.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   i_valid     operand set valid
//   o_ready     block accepts an operand set this cycle (combinational)
//   i_data      packed operands, operand k = i_data[k*DATA_W +: DATA_W]
//   i_mode      format mode, sampled with the operands
//   o_valid     o_result / o_overflow valid
//   i_ready     downstream accepts the result
//   o_result    formatted product
//   o_overflow  saturation / rounding overflow (modes 01 and 10 only)
// -----------------------------------------------------------------------------
module mult_tree_pipe #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NUM_IN*DATA_W-1:0] i_data,
  input  logic [1:0]               i_mode,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [OUT_W-1:0]         o_result,
  output logic                     o_overflow
);

  localparam int FULL_W = NUM_IN * DATA_W;
  localparam int LVL    = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    MODE_TRUNC_HI = 2'b00,
    MODE_SAT_LO   = 2'b01,
    MODE_ROUND_HI = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  // Stage j holds NUM_IN>>j partial products of (2^j)*DATA_W bits each, so
  // every stage is exactly FULL_W bits wide. Stage 0 is the input register.
  logic [LVL:0][FULL_W-1:0] lvl_d;
  logic [LVL:0][FULL_W-1:0] data_q;
  logic [LVL:0][1:0]        mode_q;
  logic [LVL:0]             vld_q;

  logic                     advance;
  logic                     out_vld_q;
  logic [OUT_W-1:0]         res_q, res_d;
  logic                     ovf_q, ovf_d;

  // The entire pipeline moves as one; it only stalls when a valid result
  // is being refused by downstream.
  assign advance = i_ready | ~out_vld_q;
  assign o_ready = advance;

  // Bubbles carry zero data so a non-accepted i_data never reaches the tree.
  assign lvl_d[0] = i_valid ? i_data : '0;

  for (genvar j = 1; j <= LVL; j++) begin : g_lvl
    localparam int PW = DATA_W << j;  // product width at this level
    localparam int AW = PW / 2;       // operand width from previous level
    for (genvar k = 0; k < (NUM_IN >> j); k++) begin : g_mul
      logic [PW-1:0] op_a, op_b;
      // Zero-extend before multiplying so the product keeps full precision.
      assign op_a = {{AW{1'b0}}, data_q[j-1][(2*k)*AW   +: AW]};
      assign op_b = {{AW{1'b0}}, data_q[j-1][(2*k+1)*AW +: AW]};
      assign lvl_d[j][k*PW +: PW] = op_a * op_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Format stage
  // ---------------------------------------------------------------------------
  logic [FULL_W-1:0] prod;
  logic [OUT_W-1:0]  prod_hi, prod_lo;
  logic              hi_nz, rnd_bit;
  logic [OUT_W:0]    rnd_sum;

  assign prod    = data_q[LVL];
  assign prod_hi = prod[FULL_W-1 -: OUT_W];
  assign prod_lo = prod[OUT_W-1:0];

  if (OUT_W < FULL_W) begin : g_narrow
    assign hi_nz   = |prod[FULL_W-1:OUT_W];    // P >= 2^OUT_W
    assign rnd_bit = prod[FULL_W-OUT_W-1];     // first bit below the kept field
  end else begin : g_full
    assign hi_nz   = 1'b0;
    assign rnd_bit = 1'b0;
  end

  // One extra bit catches the carry out of the rounding increment.
  assign rnd_sum = {1'b0, prod_hi} + {{OUT_W{1'b0}}, rnd_bit};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    res_d = prod_hi;
    ovf_d = 1'b0;
    case (mode_e'(mode_q[LVL]))
      MODE_SAT_LO: begin
        if (hi_nz) begin
          res_d = '1;
          ovf_d = 1'b1;
        end else begin
          res_d = prod_lo;
        end
      end
      MODE_ROUND_HI: begin
        if (rnd_sum[OUT_W]) begin
          res_d = '1;
          ovf_d = 1'b1;
        end else begin
          res_d = rnd_sum[OUT_W-1:0];
        end
      end
      default: ;  // truncate-high, also used for the reserved mode
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pipeline registers are reset too, not only the valid bits,
      // because the result and overflow must read zero during reset.
      vld_q     <= '0;
      data_q    <= '0;
      mode_q    <= '0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (advance) begin
      vld_q     <= {vld_q[LVL-1:0], i_valid};
      data_q    <= lvl_d;
      mode_q    <= {mode_q[LVL-1:0], (i_valid ? i_mode : 2'b00)};
      out_vld_q <= vld_q[LVL];
      res_q     <= res_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_valid    = out_vld_q;
  assign o_result   = res_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_mult_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mult_tree_pipe
//   Directed self-checking bench. Instance a: 4 operands x 4 bits -> 8 bits.
//   Instance b: 2 operands x 4 bits -> 2 bits, used for round-carry cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a (4/4/8)
  logic        a_in_valid, a_out_ready, a_out_valid, a_in_ready, a_ovf;
  logic [15:0] a_data;
  logic [1:0]  a_mode;
  logic [7:0]  a_result;

  // Instance b (2/4/2)
  logic        b_in_valid, b_out_ready, b_out_valid, b_in_ready, b_ovf;
  logic [7:0]  b_data;
  logic [1:0]  b_mode;
  logic [1:0]  b_result;

  int n_checks = 0;
  int n_errors = 0;

  mult_tree_pipe #(.NUM_IN(4), .DATA_W(4), .OUT_W(8)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (a_in_valid),
    .o_ready    (a_out_ready),
    .i_data     (a_data),
    .i_mode     (a_mode),
    .o_valid    (a_out_valid),
    .i_ready    (a_in_ready),
    .o_result   (a_result),
    .o_overflow (a_ovf)
  );

  mult_tree_pipe #(.NUM_IN(2), .DATA_W(4), .OUT_W(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (b_in_valid),
    .o_ready    (b_out_ready),
    .i_data     (b_data),
    .i_mode     (b_mode),
    .o_valid    (b_out_valid),
    .i_ready    (b_in_ready),
    .o_result   (b_result),
    .o_overflow (b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One set through instance a: 4-edge latency, then drained.
  task automatic single_a(input string tag, input logic [15:0] data,
                          input logic [1:0] mode, input logic [7:0] exp_res,
                          input logic exp_ovf);
    a_in_ready = 1'b1;
    a_in_valid = 1'b1;
    a_data     = data;
    a_mode     = mode;
    tick();
    a_in_valid = 1'b0;
    a_data     = 16'hDEAD;  // ignored while not valid
    tick();
    tick();
    check({tag, "_early"}, a_out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, a_out_valid, 1'b1);
    check({tag, "_res"},   a_result,    exp_res);
    check({tag, "_ovf"},   a_ovf,       exp_ovf);
    tick();
  endtask

  // One set through instance b: 3-edge latency.
  task automatic single_b(input string tag, input logic [7:0] data,
                          input logic [1:0] mode, input logic [1:0] exp_res,
                          input logic exp_ovf);
    b_in_valid = 1'b1;
    b_data     = data;
    b_mode     = mode;
    tick();
    b_in_valid = 1'b0;
    tick();
    check({tag, "_early"}, b_out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, b_out_valid, 1'b1);
    check({tag, "_res"},   b_result,    exp_res);
    check({tag, "_ovf"},   b_ovf,       exp_ovf);
    tick();
  endtask

  // Six sets {k+1, base, 1, 1} in mode 01, so result k is base*(k+1).
  // stall_mode 0: i_ready low for 3 cycles after the 2nd result.
  // stall_mode 1: i_ready toggles every cycle.
  task automatic stream_a(input string tag, input int base, input bit toggle);
    int sent  = 0;
    int rcvd  = 0;
    int stall = 0;
    int cyc   = 0;
    a_mode = 2'b01;
    while (rcvd < 6 && cyc < 60) begin
      a_in_valid = (sent < 6);
      a_data     = {4'd1, 4'd1, 4'(base), 4'(sent + 1)};
      if (toggle) a_in_ready = cyc[0];
      else        a_in_ready = !(rcvd == 2 && stall < 3);
      #1;
      if (!toggle && rcvd == 2 && stall < 3) begin
        check({tag, "_stall_valid"}, a_out_valid, 1'b1);
        check({tag, "_stall_ready"}, a_out_ready, 1'b0);
        stall++;
      end
      if (a_out_valid) begin
        check({tag, "_res"}, a_result, 8'(base * (rcvd + 1)));
        check({tag, "_ovf"}, a_ovf, 1'b0);
        if (!a_in_ready) check({tag, "_held_ready"}, a_out_ready, 1'b0);
        else rcvd++;
      end else begin
        check({tag, "_idle_ready"}, a_out_ready, 1'b1);
      end
      if (a_in_valid && a_out_ready) sent++;
      tick();
      cyc++;
    end
    check({tag, "_count"}, rcvd, 6);
    a_in_valid = 1'b0;
    a_in_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check({tag, "_no_dup"}, a_out_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    a_in_valid = 1'b0; a_in_ready = 1'b0; a_data = '0; a_mode = '0;
    b_in_valid = 1'b0; b_in_ready = 1'b1; b_data = '0; b_mode = '0;
    #1;
    check("rst_valid",  a_out_valid, 1'b0);
    check("rst_result", a_result,    8'h00);
    check("rst_ovf",    a_ovf,       1'b0);
    check("rst_ready",  a_out_ready, 1'b1);
    check("rst_b_valid", b_out_valid, 1'b0);
    a_in_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // {15,15,15,15}: P = 0xC5C1
    single_a("ffff_m0", 16'hFFFF, 2'b00, 8'hC5, 1'b0);
    single_a("ffff_m1", 16'hFFFF, 2'b01, 8'hFF, 1'b1);
    single_a("ffff_m2", 16'hFFFF, 2'b10, 8'hC6, 1'b0);
    single_a("ffff_m3", 16'hFFFF, 2'b11, 8'hC5, 1'b0);
    // {3,5,2,7}: P = 0x00D2
    single_a("d2_m1", 16'h7253, 2'b01, 8'hD2, 1'b0);
    single_a("d2_m0", 16'h7253, 2'b00, 8'h00, 1'b0);
    single_a("d2_m2", 16'h7253, 2'b10, 8'h01, 1'b0);
    // {4,4,4,4}: P = 256, just past the saturation threshold
    single_a("p256_m1", 16'h4444, 2'b01, 8'hFF, 1'b1);
    // {3,0,2,7}: zero operand
    single_a("zero_m0", 16'h7203, 2'b00, 8'h00, 1'b0);
    single_a("zero_m1", 16'h7203, 2'b01, 8'h00, 1'b0);
    single_a("zero_m2", 16'h7203, 2'b10, 8'h00, 1'b0);

    // 2/4/2, {15,15}: P = 0xE1
    single_b("b_e1_m2", 8'hFF, 2'b10, 2'b11, 1'b1);
    single_b("b_e1_m0", 8'hFF, 2'b00, 2'b11, 1'b0);
    single_b("b_e1_m1", 8'hFF, 2'b01, 2'b11, 1'b1);
    // {2,1}: P = 2
    single_b("b_p2_m1", 8'h12, 2'b01, 2'b10, 1'b0);
    single_b("b_p2_m2", 8'h12, 2'b10, 2'b00, 1'b0);

    // Throughput: 8 back-to-back sets {c+1,3,1,1} in mode 01 -> 3*(c+1)
    a_in_ready = 1'b1;
    a_mode     = 2'b01;
    for (int c = 0; c < 12; c++) begin
      a_in_valid = (c < 8);
      a_data     = {4'd1, 4'd1, 4'd3, 4'(c + 1)};
      #1;
      check("tp_ready", a_out_ready, 1'b1);
      tick();
      if (c >= 3 && c < 11) begin
        check("tp_valid", a_out_valid, 1'b1);
        check("tp_res",   a_result,    8'(3 * (c - 2)));
      end else begin
        check("tp_bubble", a_out_valid, 1'b0);
      end
    end
    a_in_valid = 1'b0;

    stream_a("bp",  5, 1'b0);
    stream_a("tgl", 7, 1'b1);

    // Reset with sets in flight: first set at the output, two behind it.
    a_in_ready = 1'b1;
    a_mode     = 2'b01;
    a_data     = 16'hFFFF;
    a_in_valid = 1'b1;
    tick();
    tick();
    tick();
    a_in_valid = 1'b0;
    tick();
    check("pre_rst_valid", a_out_valid, 1'b1);
    check("pre_rst_res",   a_result,    8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", a_out_valid, 1'b0);
    check("async_rst_res",   a_result,    8'h00);
    check("async_rst_ovf",   a_ovf,       1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", a_out_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_stale", a_out_valid, 1'b0);
    end
    single_a("post_rst_d2", 16'h7253, 2'b01, 8'hD2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
